// File: rtl/freq_gate_pkg.sv
// Shared types and default sizing for the frequency-meter gate counter.
package freq_gate_pkg;

   localparam int unsigned DefaultCntW     = 27;
   localparam int unsigned DefaultMaxCount = 99_999_999;
   localparam int unsigned DefaultDigits   = 8;

   typedef enum logic [2:0] {
      StArm,
      StIdle,
      StCount,
      StConvert,
      StDone
   } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 iteration per cycle,
// CNT_W iterations in total, one-cycle done pulse when bcd holds the result.
module bin2bcd_seq
   import freq_gate_pkg::*;
#(
   parameter int unsigned CNT_W  = DefaultCntW,
   parameter int unsigned DIGITS = DefaultDigits
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);

   localparam int unsigned IterW = $clog2(CNT_W + 1);

   logic [CNT_W-1:0]    shift_q, shift_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [IterW-1:0]    iter_q, iter_d;
   logic                run_q, run_d;

   // Add 3 to every digit of 5 or more ahead of the next shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
   end

   // Iteration control. The first iteration runs in the start cycle (bcd is
   // still zero, so no adjust is needed), leaving CNT_W-1 more to go.
   always_comb begin
      shift_d = shift_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      run_d   = run_q;
      if (!run_q) begin
         if (start) begin
            run_d   = 1'b1;
            iter_d  = IterW'(CNT_W - 1);
            shift_d = bin << 1;
            bcd_d   = {{(4*DIGITS-1){1'b0}}, bin[CNT_W-1]};
         end
      end else if (iter_q != '0) begin
         shift_d = shift_q << 1;
         bcd_d   = {bcd_adj[4*DIGITS-2:0], shift_q[CNT_W-1]};
         iter_d  = iter_q - IterW'(1);
      end else begin
         run_d = 1'b0;
      end
   end

   // Converter state registers.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         run_q   <= run_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = run_q && (iter_q == '0);

endmodule

// File: rtl/freq_gate_counter.sv
// Gate-window frequency counter: counts synchronized sig_in rising edges while
// the gate is high, then converts the count to BCD and reports it with a pulse.
module freq_gate_counter
   import freq_gate_pkg::*;
#(
   parameter int unsigned CNT_W     = DefaultCntW,
   parameter int unsigned MAX_COUNT = DefaultMaxCount,
   parameter int unsigned DIGITS    = DefaultDigits
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic                  gate_in,
   input  logic                  sig_in,
   output logic [CNT_W-1:0]      freq_bin,
   output logic [4*DIGITS-1:0]   freq_bcd,
   output logic                  overflow,
   output logic                  meas_valid,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

   logic gate_meta_q, gate_sync_q, gate_dly_q;
   logic sig_meta_q, sig_sync_q, sig_dly_q;
   logic gate_rise, gate_fall, sig_rise;

   state_e           state_q, state_d;
   logic [1:0]       arm_cnt_q, arm_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             conv_start, conv_done, latch;
   logic [4*DIGITS-1:0] conv_bcd;

   logic [CNT_W-1:0]    freq_bin_q;
   logic [4*DIGITS-1:0] freq_bcd_q;
   logic                overflow_q, meas_valid_q;

   // Two-flop synchronizers plus a delay stage for edge detection.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         gate_meta_q <= 1'b0;
         gate_sync_q <= 1'b0;
         gate_dly_q  <= 1'b0;
         sig_meta_q  <= 1'b0;
         sig_sync_q  <= 1'b0;
         sig_dly_q   <= 1'b0;
      end else begin
         gate_meta_q <= gate_in;
         gate_sync_q <= gate_meta_q;
         gate_dly_q  <= gate_sync_q;
         sig_meta_q  <= sig_in;
         sig_sync_q  <= sig_meta_q;
         sig_dly_q   <= sig_sync_q;
      end
   end

   assign gate_rise = gate_sync_q & ~gate_dly_q;
   assign gate_fall = ~gate_sync_q & gate_dly_q;
   assign sig_rise  = sig_sync_q & ~sig_dly_q;

   // Measurement FSM and saturating edge counter.
   always_comb begin
      state_d    = state_q;
      arm_cnt_d  = arm_cnt_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      conv_start = 1'b0;
      latch      = 1'b0;
      unique case (state_q)
         StArm: begin
            // The synchronizer reads its reset value (low) until it has
            // sampled the pin, so let it fill before trusting gate_sync_q.
            if (arm_cnt_q != 2'd3) begin
               arm_cnt_d = arm_cnt_q + 2'd1;
            end else if (!gate_sync_q) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (gate_rise) begin
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = StCount;
            end
         end
         StCount: begin
            if (gate_fall) begin
               conv_start = 1'b1;
               state_d    = StConvert;
            end else if (sig_rise) begin
               if (count_q >= MaxCnt) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         StConvert: begin
            if (conv_done) begin
               state_d = StDone;
            end
         end
         StDone: begin
            latch   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StArm;
      endcase
   end

   // FSM and counter registers.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q   <= StArm;
         arm_cnt_q <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   bin2bcd_seq #(
      .CNT_W  (CNT_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .sysclk (sysclk),
      .reset  (reset),
      .start  (conv_start),
      .bin    (count_q),
      .bcd    (conv_bcd),
      .done   (conv_done)
   );

   // Result registers: loaded in DONE, held until the next DONE.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         freq_bin_q   <= '0;
         freq_bcd_q   <= '0;
         overflow_q   <= 1'b0;
         meas_valid_q <= 1'b0;
      end else begin
         meas_valid_q <= latch;
         if (latch) begin
            freq_bin_q <= count_q;
            freq_bcd_q <= conv_bcd;
            overflow_q <= ovf_q;
         end
      end
   end

   assign freq_bin   = freq_bin_q;
   assign freq_bcd   = freq_bcd_q;
   assign overflow   = overflow_q;
   assign meas_valid = meas_valid_q;
   assign busy       = (state_q == StCount) || (state_q == StConvert);

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter: stimulus pushes expected results,
// a monitor pops and compares them on every meas_valid pulse.
module tb_freq_gate_counter;

   localparam int unsigned CNT_W     = 27;
   localparam int unsigned MAX_COUNT = 999;
   localparam int unsigned DIGITS    = 8;

   logic                  sysclk = 1'b0;
   logic                  reset;
   logic                  gate_in;
   logic                  sig_in;
   logic [CNT_W-1:0]      freq_bin;
   logic [4*DIGITS-1:0]   freq_bcd;
   logic                  overflow;
   logic                  meas_valid;
   logic                  busy;

   typedef struct {
      longint     bin;
      logic [31:0] bcd;
      logic       ovf;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   expect_low = 1'b0;

   freq_gate_counter #(
      .CNT_W     (CNT_W),
      .MAX_COUNT (MAX_COUNT),
      .DIGITS    (DIGITS)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .gate_in    (gate_in),
      .sig_in     (sig_in),
      .freq_bin   (freq_bin),
      .freq_bcd   (freq_bcd),
      .overflow   (overflow),
      .meas_valid (meas_valid),
      .busy       (busy)
   );

   always #5 sysclk = ~sysclk;

   initial forever begin
      @(posedge sysclk);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every meas_valid pulse must match the oldest expected result and
   // be exactly one cycle wide.
   initial begin
      exp_t e;
      forever begin
         @(negedge sysclk);
         if (expect_low) begin
            check("valid_one_cycle", longint'(meas_valid), 0);
            expect_low = 1'b0;
         end else if (meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid: meas_valid at cycle %0d, no result expected",
                        cyc);
            end else begin
               e = sb.pop_front();
               check("freq_bin", longint'(freq_bin), e.bin);
               check("freq_bcd", longint'(freq_bcd), longint'(e.bcd));
               check("overflow", longint'(overflow), longint'(e.ovf));
               check("valid_cycle", longint'(cyc), longint'(e.cyc));
            end
            expect_low = 1'b1;
         end
      end
   end

   // One gate window of 'high' cycles, driven from a negedge. sig_in is high
   // when (i % period) >= period/2, so the rising edges sit at i = period/2 +
   // k*period. The gate fall is driven at cycle c: two synchronizer flops put
   // the detect pulse in the cycle from posedge c+2, and meas_valid follows 29
   // cycles later, i.e. from posedge c+31.
   task automatic window(input int high, input int period, input longint exp_bin,
                         input logic [31:0] exp_bcd, input logic exp_ovf,
                         input bit push, input bit chk_busy, input int tail);
      exp_t e;
      for (int i = 0; i < high; i++) begin
         if (chk_busy && i == 2) check("busy_low_at_rise", longint'(busy), 0);
         if (chk_busy && i == 3) check("busy_high_after_rise", longint'(busy), 1);
         gate_in = 1'b1;
         sig_in  = (period > 0) && ((i % period) >= (period / 2));
         @(negedge sysclk);
      end
      gate_in = 1'b0;
      sig_in  = 1'b0;
      if (push) begin
         e.bin = exp_bin;
         e.bcd = exp_bcd;
         e.ovf = exp_ovf;
         e.cyc = cyc + 31;
         sb.push_back(e);
      end
      repeat (tail) @(negedge sysclk);
   endtask

   initial begin
      exp_t e;
      reset   = 1'b1;
      gate_in = 1'b0;
      sig_in  = 1'b0;
      repeat (3) @(negedge sysclk);
      check("reset_freq_bin", longint'(freq_bin), 0);
      check("reset_freq_bcd", longint'(freq_bcd), 0);
      check("reset_overflow", longint'(overflow), 0);
      check("reset_meas_valid", longint'(meas_valid), 0);
      check("reset_busy", longint'(busy), 0);
      reset = 1'b0;
      repeat (10) @(negedge sysclk);

      // Count 100: 1000-cycle window, period 10.
      window(1000, 10, 100, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 60);
      check("hold_freq_bin", longint'(freq_bin), 100);
      check("busy_idle", longint'(busy), 0);

      // No signal.
      window(300, 0, 0, 32'h0, 1'b0, 1'b1, 1'b1, 60);

      // Saturation: 1500 edges against MAX_COUNT 999, then a clean 5-edge window.
      window(6000, 4, 999, 32'h0000_0999, 1'b1, 1'b1, 1'b1, 60);
      window(20, 4, 5, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 60);

      // Coincident edges: sig rises together with gate rise and with gate fall;
      // only the 10 rises strictly inside the window count.
      for (int i = 0; i < 65; i++) begin
         gate_in = 1'b1;
         sig_in  = (i < 2) ? 1'b1 : (((i - 2) % 6) >= 3);
         @(negedge sysclk);
      end
      gate_in = 1'b0;
      sig_in  = 1'b1;
      e.bin = 10;
      e.bcd = 32'h0000_0010;
      e.ovf = 1'b0;
      e.cyc = cyc + 31;
      sb.push_back(e);
      repeat (2) @(negedge sysclk);
      sig_in = 1'b0;
      repeat (60) @(negedge sysclk);

      // Reset mid-COUNT: outputs clear at once, that window never reports.
      for (int i = 0; i < 200; i++) begin
         gate_in = 1'b1;
         sig_in  = (i % 10) >= 5;
         @(negedge sysclk);
      end
      reset = 1'b1;
      #1;
      check("midreset_freq_bin", longint'(freq_bin), 0);
      check("midreset_freq_bcd", longint'(freq_bcd), 0);
      check("midreset_overflow", longint'(overflow), 0);
      check("midreset_meas_valid", longint'(meas_valid), 0);
      check("midreset_busy", longint'(busy), 0);
      for (int i = 0; i < 203; i++) begin
         @(negedge sysclk);
         if (i == 3) reset = 1'b0;
         sig_in = (i % 10) >= 5;
      end
      gate_in = 1'b0;
      sig_in  = 1'b0;
      repeat (60) @(negedge sysclk);
      check("hold_zero_after_reset", longint'(freq_bin), 0);
      window(500, 10, 50, 32'h0000_0050, 1'b0, 1'b1, 1'b1, 60);

      // Gate re-raised 10 cycles after its fall: that window is ignored.
      window(300, 10, 30, 32'h0000_0030, 1'b0, 1'b1, 1'b1, 10);
      window(200, 10, 0, 32'h0, 1'b0, 1'b0, 1'b0, 60);
      window(100, 10, 10, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 60);

      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge sysclk);
      check("pending_results", longint'(sb.size()), 0);
      repeat (2) @(negedge sysclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
